modular_addsub_pipe: RTL and testbench

Multi-lane, pipelined modular adder/subtractor computing c = (a ± b) mod Q per lane, for 0 <= a, b < Q.
- Next-generation replacement for the fixed 30-bit, add-only, free-running modular adder in the modular_arithmetic library.
- Adds parametrised width and lane count, a per-transaction add/sub mode, valid/ready flow control with backpressure, and reset.
- Feeds NTT butterfly datapaths, which need a+b and a-b on the same operands.

---
 rtl/modarith_pkg.sv | 10 +
 rtl/modaddsub_lane.sv | 56 +++++
 rtl/modular_addsub_pipe.sv | 86 ++++++++
 tb/tb_modular_addsub_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modarith_pkg.sv
// Shared constants for the modular arithmetic library.
//   W_DEFAULT : default operand width
//   Q_NTT30   : default NTT modulus, 2^30 - 2^18 + 1
//   OP_ADD / OP_SUB : per-transaction operation encoding
package modarith_pkg;
   localparam int unsigned W_DEFAULT = 30;
   localparam logic [29:0] Q_NTT30   = 30'd1073479681;
   localparam logic        OP_ADD    = 1'b0;
   localparam logic        OP_SUB    = 1'b1;
endpackage

// File: rtl/modaddsub_lane.sv
// One lane of the modular add/subtract pipeline: S1 forms the raw W+1-bit
// sum/difference, S2 folds it back into [0, Q). Both stages advance on en.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : pipeline advance enable
//   op        : OP_ADD / OP_SUB for the operands presented this cycle
//   a, b      : operands in [0, Q)
//   c         : registered result in [0, Q)
module modaddsub_lane
   import modarith_pkg::*;
#(
   parameter int unsigned   W = W_DEFAULT,
   parameter logic [W-1:0]  Q = Q_NTT30
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] c
);

   // bit W carries the add carry or the subtract borrow
   logic [W:0]   r;
   logic         op_q;
   logic [W:0]   r_minus_q;
   logic [W-1:0] c_nxt;

   assign r_minus_q = r - {1'b0, Q};

   always_comb begin
      c_nxt = r[W-1:0];
      if (op_q == OP_ADD) begin
         if (r >= {1'b0, Q})
            c_nxt = r_minus_q[W-1:0];
      end else begin
         // borrow: low W bits hold a-b+2^W, adding Q and dropping 2^W gives a-b+Q
         if (r[W])
            c_nxt = r[W-1:0] + Q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r    <= '0;
         op_q <= OP_ADD;
         c    <= '0;
      end else if (en) begin
         r    <= (op == OP_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
         op_q <= op;
         c    <= c_nxt;
      end
   end

endmodule

// File: rtl/modular_addsub_pipe.sv
// Multi-lane pipelined modular adder/subtractor: c = (a +/- b) mod Q per lane,
// two register stages, valid/ready handshake shared by all lanes.
// Optional feature macro: MODADDSUB_RANGE_CHECK_EN adds the sticky range_err
// output flagging any accepted operand >= Q.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready = pipeline enable)
//   op                   : 0 add, 1 subtract
//   a, b                 : lane i operand at [i*W +: W]
//   out_valid / out_ready: output handshake
//   c                    : lane i result at [i*W +: W]
//   range_err            : sticky operand-range flag (macro only)
module modular_addsub_pipe
   import modarith_pkg::*;
#(
   parameter int unsigned  W     = W_DEFAULT,
   parameter logic [W-1:0] Q     = Q_NTT30,
   parameter int unsigned  LANES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               op,
   input  logic [LANES*W-1:0] a,
   input  logic [LANES*W-1:0] b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] c
`ifdef MODADDSUB_RANGE_CHECK_EN
   ,
   output logic               range_err
`endif
);

   logic en;
   logic s1_valid;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (en) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      modaddsub_lane #(
         .W (W),
         .Q (Q)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .en  (en),
         .op  (op),
         .a   (a[i*W +: W]),
         .b   (b[i*W +: W]),
         .c   (c[i*W +: W])
      );
   end

`ifdef MODADDSUB_RANGE_CHECK_EN
   logic viol;

   always_comb begin
      viol = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (a[i*W +: W] >= Q || b[i*W +: W] >= Q)
            viol = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         range_err <= 1'b0;
      else if (in_valid && en && viol)
         range_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_modular_addsub_pipe.sv
module tb_modular_addsub_pipe;
   localparam int unsigned W     = 30;
   localparam int unsigned LANES = 4;
   localparam logic [29:0] QV    = 30'd1073479681;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               op = 1'b0;
   logic [LANES*W-1:0] a = '0;
   logic [LANES*W-1:0] b = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [LANES*W-1:0] c;
`ifdef MODADDSUB_RANGE_CHECK_EN
   logic               range_err;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   modular_addsub_pipe #(
      .W     (W),
      .Q     (QV),
      .LANES (LANES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c)
`ifdef MODADDSUB_RANGE_CHECK_EN
      ,
      .range_err (range_err)
`endif
   );

   // reference: plain integer modular arithmetic
   function automatic logic [29:0] mref(input logic opx, input logic [29:0] x, input logic [29:0] y);
      logic [31:0] s;
      if (!opx) begin
         s = {2'b0, x} + {2'b0, y};
         if (s >= {2'b0, QV}) s = s - {2'b0, QV};
      end else begin
         if (x >= y) s = {2'b0, x} - {2'b0, y};
         else        s = {2'b0, x} + {2'b0, QV} - {2'b0, y};
      end
      return s[29:0];
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || c !== '0) begin
         errors++; $display("FAIL reset_state: out_valid=%b c=%h, required 0/0", out_valid, c);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
      end
      // two transactions in flight, then reset
      for (int t = 0; t < 2; t++) begin
         in_valid = 1'b1; op = 1'b0;
         for (int i = 0; i < LANES; i++) begin
            a[i*W +: W] = 30'(5 + t);
            b[i*W +: W] = 30'd7;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || c !== '0) begin
         errors++; $display("FAIL reset_midstream: out_valid=%b c=%h, required 0/0", out_valid, c);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_no_stale: cycle %0d out_valid=%b in_ready=%b, required 0/1", k, out_valid, in_ready);
         end
      end
   endtask

   // single transaction, checks two-cycle latency and all lane results
   task automatic test_add_wrap();
      logic [29:0] ea [LANES];
      a[0*W +: W] = QV - 30'd1; b[0*W +: W] = QV - 30'd1; ea[0] = QV - 30'd2;
      a[1*W +: W] = 30'd5;      b[1*W +: W] = 30'd7;      ea[1] = 30'd12;
      a[2*W +: W] = QV - 30'd1; b[2*W +: W] = 30'd1;      ea[2] = 30'd0;
      a[3*W +: W] = 30'd0;      b[3*W +: W] = 30'd0;      ea[3] = 30'd0;
      op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL add_latency_early: out_valid=%b, required 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL add_latency: out_valid=%b, required 1", out_valid);
      end
      for (int i = 0; i < LANES; i++) begin
         checks++;
         if (c[i*W +: W] !== ea[i]) begin
            errors++; $display("FAIL add_lane%0d: c=%0d, required %0d", i, c[i*W +: W], ea[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_sub_wrap();
      logic [29:0] ea [LANES];
      a[0*W +: W] = 30'd0;      b[0*W +: W] = 30'd1;      ea[0] = QV - 30'd1;
      a[1*W +: W] = 30'd10;     b[1*W +: W] = 30'd3;      ea[1] = 30'd7;
      a[2*W +: W] = QV - 30'd1; b[2*W +: W] = QV - 30'd1; ea[2] = 30'd0;
      a[3*W +: W] = 30'd0;      b[3*W +: W] = QV - 30'd1; ea[3] = 30'd1;
      op = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL sub_latency: out_valid=%b, required 1", out_valid);
      end
      for (int i = 0; i < LANES; i++) begin
         checks++;
         if (c[i*W +: W] !== ea[i]) begin
            errors++; $display("FAIL sub_lane%0d: c=%0d, required %0d", i, c[i*W +: W], ea[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [LANES*W-1:0] ta [8];
      logic [LANES*W-1:0] tb [8];
      logic               to [8];
      logic [LANES*W-1:0] te [8];
      logic               pat [8];
      int tx = 0, rx = 0, extra = 0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int t = 0; t < 8; t++) begin
         to[t] = 1'($urandom_range(0, 1));
         for (int i = 0; i < LANES; i++) begin
            ta[t][i*W +: W] = 30'($urandom_range(0, QV - 1));
            tb[t][i*W +: W] = 30'($urandom_range(0, QV - 1));
            te[t][i*W +: W] = mref(to[t], ta[t][i*W +: W], tb[t][i*W +: W]);
         end
      end
      for (int cyc = 0; cyc < 300 && rx < 8; cyc++) begin
         @(negedge clk);
         out_ready = pat[cyc % 8];
         in_valid  = (tx < 8);
         if (tx < 8) begin a = ta[tx]; b = tb[tx]; op = to[tx]; end
         #1;
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++; $display("FAIL bp_in_ready: cycle %0d in_ready=%b, required 0", cyc, in_ready);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (c !== te[rx]) begin
               errors++; $display("FAIL bp_result%0d: c=%h, required %h", rx, c, te[rx]);
            end
            rx++;
         end
         if (in_valid && in_ready) tx++;
      end
      checks++;
      if (rx != 8) begin
         errors++; $display("FAIL bp_count: received %0d, required 8", rx);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++; $display("FAIL bp_duplicate: extra results %0d, required 0", extra);
      end
   endtask

   task automatic test_throughput();
      logic [LANES*W-1:0] ta [100];
      logic [LANES*W-1:0] tb [100];
      logic               to [100];
      logic [LANES*W-1:0] te [100];
      logic               lt;
      for (int t = 0; t < 100; t++) begin
         to[t] = 1'($urandom_range(0, 1));
         for (int i = 0; i < LANES; i++) begin
            ta[t][i*W +: W] = 30'($urandom_range(0, QV - 1));
            tb[t][i*W +: W] = 30'($urandom_range(0, QV - 1));
            te[t][i*W +: W] = mref(to[t], ta[t][i*W +: W], tb[t][i*W +: W]);
         end
      end
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 102; cyc++) begin
         @(negedge clk);
         if (cyc >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || c !== te[cyc-2]) begin
               errors++; $display("FAIL tp_result%0d: out_valid=%b c=%h, required 1/%h", cyc - 2, out_valid, c, te[cyc-2]);
            end
            lt = 1'b0;
            for (int i = 0; i < LANES; i++) if (c[i*W +: W] >= QV) lt = 1'b1;
            checks++;
            if (lt !== 1'b0) begin
               errors++; $display("FAIL tp_range%0d: c=%h has lane >= Q, required all < Q", cyc - 2, c);
            end
         end else begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++; $display("FAIL tp_early%0d: out_valid=%b, required 0", cyc, out_valid);
            end
         end
         in_valid = (cyc < 100);
         if (cyc < 100) begin a = ta[cyc]; b = tb[cyc]; op = to[cyc]; end
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

`ifdef MODADDSUB_RANGE_CHECK_EN
   task automatic test_range_err();
      checks++;
      if (range_err !== 1'b0) begin
         errors++; $display("FAIL range_clear: range_err=%b, required 0", range_err);
      end
      out_ready = 1'b1; op = 1'b0;
      a = '0; b = '0; a[0*W +: W] = QV;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (range_err !== 1'b1) begin
         errors++; $display("FAIL range_set: range_err=%b, required 1", range_err);
      end
      a = '0; b = '0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; a[0*W +: W] = 30'(k);
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (range_err !== 1'b1) begin
         errors++; $display("FAIL range_sticky: range_err=%b, required 1", range_err);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (range_err !== 1'b0) begin
         errors++; $display("FAIL range_reset: range_err=%b, required 0", range_err);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_add_wrap();
      test_sub_wrap();
      test_backpressure();
      test_throughput();
`ifdef MODADDSUB_RANGE_CHECK_EN
      test_range_err();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
